// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter in front of a single-port synchronous memory.
module mem_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_nx;
    logic prio, port, lat_we, win1, start, finish;
    // prio=1 favours port 1 when both request
    assign win1   = req1 & (~req0 | prio);
    assign start  = (state == IDLE) & (req0 | req1);
    assign finish = ((state == ISSUE) & lat_we) | (state == WAIT);
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = IDLE;
        if (state == IDLE) state_nx = (req0 | req1) ? ISSUE : IDLE;
        else if (state == ISSUE) state_nx = lat_we ? IDLE : WAIT;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            prio      <= 1'b0;
            port      <= 1'b0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
            done0     <= 1'b0;
            done1     <= 1'b0;
        end else begin
            done0 <= finish & ~port;
            done1 <= finish & port;
            if (start) begin
                port      <= win1;
                prio      <= ~win1;
                lat_we    <= win1 ? we1 : we0;
                mem_addr  <= win1 ? addr1 : addr0;
                mem_wdata <= win1 ? wdata1 : wdata0;
            end
            if (state == WAIT && port) rdata1 <= mem_rdata;
            if (state == WAIT && !port) rdata0 <= mem_rdata;
        end
    end
    assign gnt0   = (state == ISSUE) & ~port;
    assign gnt1   = (state == ISSUE) & port;
    assign mem_en = state == ISSUE;
    assign mem_we = mem_en & lat_we;
    assign busy   = state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven vectors plus directed sequences for reset-abort and dropped requests.
module tb_mem_arbiter;
    localparam logic H = 1'b1, L = 1'b0;
    logic clock = 1'b0, reset = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic gnt0, gnt1, done0, done1, mem_en, mem_we, busy;
    logic [15:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [7:0] mem_addr;
    logic [15:0] mem [256];
    int checks = 0, failures = 0;

    mem_arbiter #(.DATA_W(16), .ADDR_W(8)) dut (
        .clock(clock), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    // memory model: one-cycle read latency, contents preset to A000|addr during reset
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic r0, w0; logic [7:0] a0; logic [15:0] d0;
        logic r1, w1; logic [7:0] a1;
        logic g0, g1, dn0, dn1, en, we, bsy;
        logic [7:0] ma; logic [15:0] md, rd0, rd1;
    } vec_t;
    vec_t tv [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        chk("gnt_overlap", 32'(gnt0 & gnt1), 32'd0);
        chk("done_overlap", 32'(done0 & done1), 32'd0);
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = '0;
    endtask

    initial begin
        // inputs before the edge -> outputs after it
        tv[0]  = '{H,H,8'h05,16'h1234, L,L,8'h00, H,L,L,L,H,H,H, 8'h05,16'h1234,16'h0000,16'h0000};
        tv[1]  = '{L,L,8'h00,16'h0000, L,L,8'h00, L,L,H,L,L,L,L, 8'h05,16'h1234,16'h0000,16'h0000};
        tv[2]  = '{L,L,8'h00,16'h0000, H,L,8'h05, L,H,L,L,H,L,H, 8'h05,16'h0000,16'h0000,16'h0000};
        tv[3]  = '{L,L,8'h00,16'h0000, L,L,8'h00, L,L,L,L,L,L,H, 8'h05,16'h0000,16'h0000,16'h0000};
        tv[4]  = '{L,L,8'h00,16'h0000, L,L,8'h00, L,L,L,H,L,L,L, 8'h05,16'h0000,16'h0000,16'h1234};
        tv[5]  = '{H,L,8'h05,16'h0000, H,L,8'h06, H,L,L,L,H,L,H, 8'h05,16'h0000,16'h0000,16'h1234};
        tv[6]  = '{H,L,8'h05,16'h0000, H,L,8'h06, L,L,L,L,L,L,H, 8'h05,16'h0000,16'h0000,16'h1234};
        tv[7]  = '{H,L,8'h05,16'h0000, H,L,8'h06, L,L,H,L,L,L,L, 8'h05,16'h0000,16'h1234,16'h1234};
        tv[8]  = '{H,L,8'h05,16'h0000, H,L,8'h06, L,H,L,L,H,L,H, 8'h06,16'h0000,16'h1234,16'h1234};
        tv[9]  = '{H,L,8'h05,16'h0000, H,L,8'h06, L,L,L,L,L,L,H, 8'h06,16'h0000,16'h1234,16'h1234};
        tv[10] = '{H,L,8'h05,16'h0000, H,L,8'h06, L,L,L,H,L,L,L, 8'h06,16'h0000,16'h1234,16'hA006};
        tv[11] = '{H,L,8'h05,16'h0000, H,L,8'h06, H,L,L,L,H,L,H, 8'h05,16'h0000,16'h1234,16'hA006};
        tv[12] = '{H,L,8'h05,16'h0000, H,L,8'h06, L,L,L,L,L,L,H, 8'h05,16'h0000,16'h1234,16'hA006};
        tv[13] = '{H,L,8'h05,16'h0000, H,L,8'h06, L,L,H,L,L,L,L, 8'h05,16'h0000,16'h1234,16'hA006};
        tv[14] = '{H,L,8'h05,16'h0000, H,L,8'h06, L,H,L,L,H,L,H, 8'h06,16'h0000,16'h1234,16'hA006};
        tv[15] = '{H,L,8'h10,16'h0000, L,L,8'h00, L,L,L,L,L,L,H, 8'h06,16'h0000,16'h1234,16'hA006};
        tv[16] = '{H,L,8'h10,16'h0000, L,L,8'h00, L,L,L,H,L,L,L, 8'h06,16'h0000,16'h1234,16'hA006};
        tv[17] = '{H,L,8'h10,16'h0000, L,L,8'h00, H,L,L,L,H,L,H, 8'h10,16'h0000,16'h1234,16'hA006};
        tv[18] = '{L,H,8'h20,16'hFFFF, L,L,8'h00, L,L,L,L,L,L,H, 8'h10,16'h0000,16'h1234,16'hA006};
        tv[19] = '{L,L,8'h00,16'h0000, L,L,8'h00, L,L,H,L,L,L,L, 8'h10,16'h0000,16'hA010,16'hA006};

        tick();
        tick();
        chk("rst gnt", {gnt1, gnt0}, 0);
        chk("rst done", {done1, done0}, 0);
        chk("rst mem_en/we", {mem_en, mem_we}, 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst mem_wdata", 32'(mem_wdata), 0);
        chk("rst rdata", {rdata1, rdata0}, 0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0, tv[i].r1, tv[i].w1, tv[i].a1);
            tick();
            chk($sformatf("v%0d gnt0", i), 32'(gnt0), 32'(tv[i].g0));
            chk($sformatf("v%0d gnt1", i), 32'(gnt1), 32'(tv[i].g1));
            chk($sformatf("v%0d done0", i), 32'(done0), 32'(tv[i].dn0));
            chk($sformatf("v%0d done1", i), 32'(done1), 32'(tv[i].dn1));
            chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(tv[i].en));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(tv[i].we));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].bsy));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(tv[i].ma));
            chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(tv[i].md));
            chk($sformatf("v%0d rdata0", i), 32'(rdata0), 32'(tv[i].rd0));
            chk($sformatf("v%0d rdata1", i), 32'(rdata1), 32'(tv[i].rd1));
        end

        // reset during WAIT aborts the read and restores port-0 priority
        drive(H, L, 8'h07, 16'h0, L, L, 8'h00);
        tick();
        chk("rr gnt0", 32'(gnt0), 1);
        drive(L, L, 8'h00, 16'h0, L, L, 8'h00);
        tick();
        chk("rr in wait", 32'(busy & ~mem_en), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr done", {done1, done0}, 0);
        chk("rr busy", 32'(busy), 0);
        chk("rr mem_en", 32'(mem_en), 0);
        chk("rr rdata0", 32'(rdata0), 0);
        tick();
        chk("rr late done", {done1, done0}, 0);
        drive(H, L, 8'h05, 16'h0, H, L, 8'h06);
        tick();
        chk("rr contest gnt", {gnt1, gnt0}, 32'b01);
        drive(L, L, 8'h00, 16'h0, L, L, 8'h00);
        tick();
        tick();
        chk("rr done0", 32'(done0), 1);
        chk("rr rdata0 new", 32'(rdata0), 32'hA005);

        // a port-1 pulse that never sees IDLE is dropped
        drive(H, H, 8'h08, 16'hBEEF, L, L, 8'h00);
        tick();
        chk("drop gnt0", 32'(gnt0), 1);
        drive(L, L, 8'h00, 16'h0, H, H, 8'h09);
        tick();
        chk("drop done0", 32'(done0), 1);
        chk("drop gnt1 a", 32'(gnt1), 0);
        drive(L, L, 8'h00, 16'h0, L, L, 8'h00);
        tick();
        chk("drop gnt1 b", 32'(gnt1), 0);
        chk("drop mem_en", 32'(mem_en), 0);
        chk("drop busy", 32'(busy), 0);
        chk("drop mem8", 32'(mem[8]), 32'hBEEF);
        chk("drop mem9", 32'(mem[9]), 32'hA009);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
